// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes load/store, runs a req/ready handshake to data memory,
// extends load data and registers the MEM/WB outputs; stalls upstream while busy.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] DataALU,
  input  logic [31:0] DataB,
  input  logic [4:0]  AddrD,
  input  logic        RegWEn,
  input  logic        MemRW,
  input  logic [1:0]  WBSel,
  input  logic [2:0]  funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic [31:0] PC_out,
  output logic [31:0] DataALU_out,
  output logic [31:0] DataR_out,
  output logic [4:0]  AddrD_out,
  output logic        RegWEn_out,
  output logic [1:0]  WBSel_out,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt;

  logic [31:0] l_pc, l_alu, l_b;
  logic [4:0]  l_addrd;
  logic        l_regwen, l_memrw, l_load;
  logic [1:0]  l_wbsel;
  logic [2:0]  l_f3;

  logic load, memop, mis, abort;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] b);
    case (f3[1:0])
      2'b00:   return {4{b[7:0]}};
      2'b01:   return {2{b[15:0]}};
      default: return b;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    load       = RegWEn && (WBSel == 2'b00) && !MemRW;
    memop      = load || MemRW;
    mis        = misaligned(funct3, DataALU[1:0]);
    abort      = (state == ACCESS) && !dmem_ready && (cnt == CW'(TIMEOUT_CYC - 1));
    state_next = state;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (memop && !mis) begin
          stall_out  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // the abort cycle releases the pipe just like a completed access
        stall_out = !dmem_ready && !abort;
        if (dmem_ready || abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = dmem_req && l_memrw;
  assign dmem_addr  = {l_alu[31:2], 2'b00};
  assign dmem_wdata = wdata_of(l_f3, l_b);
  assign dmem_be    = dmem_req ? be_of(l_f3, l_alu[1:0]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      l_pc         <= '0;
      l_alu        <= '0;
      l_b          <= '0;
      l_addrd      <= '0;
      l_regwen     <= 1'b0;
      l_memrw      <= 1'b0;
      l_load       <= 1'b0;
      l_wbsel      <= '0;
      l_f3         <= '0;
      PC_out       <= '0;
      DataALU_out  <= '0;
      DataR_out    <= '0;
      AddrD_out    <= '0;
      RegWEn_out   <= 1'b0;
      WBSel_out    <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state        <= state_next;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (memop && !mis) begin
            l_pc        <= PC;
            l_alu       <= DataALU;
            l_b         <= DataB;
            l_addrd     <= AddrD;
            l_regwen    <= RegWEn;
            l_memrw     <= MemRW;
            l_load      <= load;
            l_wbsel     <= WBSel;
            l_f3        <= funct3;
            cnt         <= '0;
            PC_out      <= '0;
            DataALU_out <= '0;
            DataR_out   <= '0;
            AddrD_out   <= '0;
            RegWEn_out  <= 1'b0;
            WBSel_out   <= '0;
          end else begin
            PC_out       <= PC;
            DataALU_out  <= DataALU;
            DataR_out    <= '0;
            AddrD_out    <= AddrD;
            RegWEn_out   <= RegWEn && !memop;
            WBSel_out    <= WBSel;
            misalign_err <= memop;
          end
        end
        ACCESS: begin
          if (dmem_ready || abort) begin
            PC_out      <= l_pc;
            DataALU_out <= l_alu;
            AddrD_out   <= l_addrd;
            WBSel_out   <= l_wbsel;
            RegWEn_out  <= dmem_ready && l_regwen;
            DataR_out   <= (dmem_ready && l_load) ? load_ext(l_f3, l_alu[1:0], dmem_rdata) : '0;
            bus_err     <= !dmem_ready;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads/stores of each width,
// misalignment, timeout abort and reset during an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, DataALU, DataB;
  logic [4:0]  AddrD;
  logic        RegWEn, MemRW;
  logic [1:0]  WBSel;
  logic [2:0]  funct3;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_out;
  logic [31:0] PC_out, DataALU_out, DataR_out;
  logic [4:0]  AddrD_out;
  logic        RegWEn_out;
  logic [1:0]  WBSel_out;
  logic        misalign_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .PC(PC), .DataALU(DataALU), .DataB(DataB),
    .AddrD(AddrD), .RegWEn(RegWEn), .MemRW(MemRW), .WBSel(WBSel), .funct3(funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_out(stall_out), .PC_out(PC_out),
    .DataALU_out(DataALU_out), .DataR_out(DataR_out), .AddrD_out(AddrD_out),
    .RegWEn_out(RegWEn_out), .WBSel_out(WBSel_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rd, input logic we, input logic mrw,
                        input logic [1:0] wbs, input logic [2:0] f3);
    PC = pc; DataALU = alu; DataB = b; AddrD = rd;
    RegWEn = we; MemRW = mrw; WBSel = wbs; funct3 = f3;
  endtask

  task automatic nop;
    set_in(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd1, 3'd0);
  endtask

  // Memory op that completes in the first ACCESS cycle; caller has set the inputs.
  task automatic fast_op(input string tag, input logic [31:0] rdata, input logic we,
                         input logic [3:0] be, input logic [31:0] wd, input logic exp_wen,
                         input logic [31:0] exp_r);
    #1;
    check({tag, " stall_idle"}, 32'(stall_out), 32'd1);
    tick;
    check({tag, " req"}, 32'(dmem_req), 32'd1);
    check({tag, " we"}, 32'(dmem_we), 32'(we));
    check({tag, " be"}, 32'(dmem_be), 32'(be));
    if (we) check({tag, " wdata"}, dmem_wdata, wd);
    dmem_ready = 1'b1;
    dmem_rdata = rdata;
    #1;
    check({tag, " stall_ready"}, 32'(stall_out), 32'd0);
    nop;
    tick;
    dmem_ready = 1'b0;
    check({tag, " DataR"}, DataR_out, exp_r);
    check({tag, " RegWEn"}, 32'(RegWEn_out), 32'(exp_wen));
    check({tag, " req_after"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    nop;
    tick;
    tick;
    check("rst PC_out", PC_out, 32'h0);
    check("rst RegWEn", 32'(RegWEn_out), 32'd0);
    check("rst req", 32'(dmem_req), 32'd0);
    reset = 1'b0;

    // ALU op
    set_in(32'h100, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 2'd1, 3'd0);
    #1;
    check("alu stall", 32'(stall_out), 32'd0);
    tick;
    check("alu DataALU_out", DataALU_out, 32'h1234);
    check("alu PC_out", PC_out, 32'h100);
    check("alu AddrD_out", 32'(AddrD_out), 32'd5);
    check("alu RegWEn_out", 32'(RegWEn_out), 32'd1);
    check("alu WBSel_out", 32'(WBSel_out), 32'd1);
    check("alu stall2", 32'(stall_out), 32'd0);

    // LB at 0x103
    set_in(32'h200, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 2'd0, 3'b000);
    #1;
    check("lb bubble_pre", 32'(dmem_req), 32'd0);
    fast_op("lb", 32'h80FF_0000, 1'b0, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80);
    check("lb AddrD_out", 32'(AddrD_out), 32'd7);
    check("lb PC_out", PC_out, 32'h200);

    // SH at 0x102, ready in fourth ACCESS cycle (also the timeout boundary)
    set_in(32'h300, 32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 2'd1, 3'b001);
    #1;
    check("sh stall_idle", 32'(stall_out), 32'd1);
    tick;
    check("sh RegWEn_bubble", 32'(RegWEn_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("sh stall_wait", 32'(stall_out), 32'd1);
      check("sh req", 32'(dmem_req), 32'd1);
      check("sh be", 32'(dmem_be), 32'hC);
      check("sh wdata", dmem_wdata, 32'hABCD_ABCD);
      check("sh addr", dmem_addr, 32'h100);
      tick;
    end
    check("sh req4", 32'(dmem_req), 32'd1);
    check("sh we4", 32'(dmem_we), 32'd1);
    dmem_ready = 1'b1;
    #1;
    check("sh stall_done", 32'(stall_out), 32'd0);
    nop;
    tick;
    dmem_ready = 1'b0;
    check("sh bus_err", 32'(bus_err), 32'd0);
    check("sh DataALU_out", DataALU_out, 32'h102);
    check("sh req_after", 32'(dmem_req), 32'd0);

    // LW misaligned
    set_in(32'h400, 32'h101, 32'h0, 5'd3, 1'b1, 1'b0, 2'd0, 3'b010);
    #1;
    check("lw_mis stall", 32'(stall_out), 32'd0);
    tick;
    check("lw_mis err", 32'(misalign_err), 32'd1);
    check("lw_mis RegWEn", 32'(RegWEn_out), 32'd0);
    check("lw_mis req", 32'(dmem_req), 32'd0);
    // SW misaligned directly after: err stays high, no write
    set_in(32'h404, 32'h102, 32'h55, 5'd0, 1'b0, 1'b1, 2'd1, 3'b010);
    #1;
    check("sw_mis we", 32'(dmem_we), 32'd0);
    tick;
    check("sw_mis err", 32'(misalign_err), 32'd1);
    check("sw_mis we2", 32'(dmem_we), 32'd0);
    nop;
    tick;
    check("mis err_clear", 32'(misalign_err), 32'd0);

    // Timeout: LW at 0x200, never ready
    set_in(32'h500, 32'h200, 32'h0, 5'd9, 1'b1, 1'b0, 2'd0, 3'b010);
    tick;
    for (int i = 0; i < 3; i++) begin
      check("to stall_wait", 32'(stall_out), 32'd1);
      tick;
    end
    check("to stall_abort", 32'(stall_out), 32'd0);
    check("to req_abort", 32'(dmem_req), 32'd1);
    nop;
    tick;
    check("to bus_err", 32'(bus_err), 32'd1);
    check("to RegWEn", 32'(RegWEn_out), 32'd0);
    check("to req_idle", 32'(dmem_req), 32'd0);
    tick;
    check("to bus_err_clear", 32'(bus_err), 32'd0);

    // Reset during ACCESS
    set_in(32'h600, 32'h001, 32'h0, 5'd4, 1'b1, 1'b0, 2'd0, 3'b100);
    tick;
    check("rst_acc req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    nop;
    tick;
    reset = 1'b0;
    check("rst_acc req", 32'(dmem_req), 32'd0);
    check("rst_acc DataALU_out", DataALU_out, 32'h0);
    check("rst_acc stall", 32'(stall_out), 32'd0);

    // Extension and lane variants after reset
    set_in(32'h700, 32'h002, 32'h0, 5'd1, 1'b1, 1'b0, 2'd0, 3'b101);
    fast_op("lhu", 32'h8001_0000, 1'b0, 4'b1100, 32'h0, 1'b1, 32'h0000_8001);
    set_in(32'h704, 32'h002, 32'h0, 5'd1, 1'b1, 1'b0, 2'd0, 3'b001);
    fast_op("lh", 32'h8001_0000, 1'b0, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001);
    set_in(32'h708, 32'h001, 32'h0, 5'd1, 1'b1, 1'b0, 2'd0, 3'b100);
    fast_op("lbu", 32'h0000_9A00, 1'b0, 4'b0010, 32'h0, 1'b1, 32'h0000_009A);
    set_in(32'h70C, 32'h001, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 2'd1, 3'b000);
    fast_op("sb", 32'h0, 1'b1, 4'b0010, 32'h7878_7878, 1'b0, 32'h0);
    set_in(32'h710, 32'h004, 32'h0, 5'd2, 1'b1, 1'b0, 2'd0, 3'b111);
    fast_op("lw111", 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
